// File: rtl/gf_pkg.sv
// gf_pkg: shared types and constants for the GF(2^M) inverter.
//   state_t     : inverter control states (IDLE, CALC, DONE).
//   GFxx_POLY   : default primitive polynomials (M+1 bits, MSB set) for M=2..8.
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] GF4_POLY   = 3'b111;        // x^2+x+1
    localparam logic [3:0] GF8_POLY   = 4'b1011;       // x^3+x+1
    localparam logic [4:0] GF16_POLY  = 5'b10011;      // x^4+x+1
    localparam logic [5:0] GF32_POLY  = 6'b100101;     // x^5+x^2+1
    localparam logic [6:0] GF64_POLY  = 7'b1000011;    // x^6+x+1
    localparam logic [7:0] GF128_POLY = 8'b10001001;   // x^7+x^3+1
    localparam logic [8:0] GF256_POLY = 9'b100011101;  // x^8+x^4+x^3+x^2+1

endpackage

// File: rtl/gf_mult_m.sv
// gf_mult_m: purely combinational GF(2^M) multiplier, p = a*b mod POLY.
// Ports:
//   a, b : M-bit field operands
//   p    : M-bit product
// Built as a shift-and-add chain: xs[i] = a*x^i reduced, and the partial
// sum pp[i] accumulates xs[j] for every set bit b[j], j<=i.
module gf_mult_m #(
    parameter int         M    = 3,
    parameter logic [M:0] POLY = 4'b1011
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);

    logic [M-1:0] xs [M];
    logic [M-1:0] pp [M];

    assign xs[0] = a;
    assign pp[0] = b[0] ? a : '0;

    generate
        for (genvar gi = 1; gi < M; gi++) begin : g_stage
            // Multiply by x; if the degree-M term appears, fold it back in
            // using the low M bits of the field polynomial.
            assign xs[gi] = {xs[gi-1][M-2:0], 1'b0}
                          ^ (xs[gi-1][M-1] ? POLY[M-1:0] : '0);
            assign pp[gi] = pp[gi-1] ^ (b[gi] ? xs[gi] : '0);
        end
    endgenerate

    assign p = pp[M-1];

endmodule

// File: rtl/gf_inv_seq.sv
// gf_inv_seq: sequential GF(2^M) multiplicative inverter, a^-1 = a^(2^M-2),
// computed by square-and-multiply, one iteration per clock (M-1 iterations).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake, in_op = operand a
//   out_valid/out_ready : result handshake, out_res = a^-1 (0 when a=0)
//   out_err             : self-check mismatch (only with GF_INV_CHECK_EN)
// Optional feature macro: GF_INV_CHECK_EN adds a third multiplier checking
// op_q*acc == 1 while the result is presented; otherwise out_err is 0.
module gf_inv_seq
    import gf_pkg::*;
#(
    parameter int         M    = 3,
    parameter logic [M:0] POLY = 4'b1011
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] out_res,
    output logic         out_err
);

    localparam int CW = (M > 2) ? $clog2(M) : 1;

    state_t        state_reg;
    logic [M-1:0]  sq_reg;
    logic [M-1:0]  acc_reg;
    logic [M-1:0]  op_q_reg;
    logic [CW-1:0] cnt_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;
    logic [M-1:0]  out_res_reg;

    logic [M-1:0]  s2;
    logic [M-1:0]  acc_next;

    // Two multipliers in series per iteration: square, then accumulate.
    gf_mult_m #(.M(M), .POLY(POLY)) u_sq (
        .a (sq_reg),
        .b (sq_reg),
        .p (s2)
    );

    gf_mult_m #(.M(M), .POLY(POLY)) u_acc (
        .a (acc_reg),
        .b (s2),
        .p (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sq_reg        <= '0;
            acc_reg       <= '0;
            op_q_reg      <= '0;
            cnt_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_res_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sq_reg       <= in_op;
                        acc_reg      <= M'(1);
                        op_q_reg     <= in_op;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    sq_reg  <= s2;
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    // Last of the M-1 iterations: acc_next already holds a^(2^M-2).
                    if (cnt_reg == CW'(M - 2)) begin
                        out_valid_reg <= 1'b1;
                        out_res_reg   <= acc_next;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_res   = out_res_reg;

`ifdef GF_INV_CHECK_EN
    logic [M-1:0] chk;

    // Checks acc (not the output copy) so an upset in the working register
    // is flagged while the result is being presented.
    gf_mult_m #(.M(M), .POLY(POLY)) u_chk (
        .a (op_q_reg),
        .b (acc_reg),
        .p (chk)
    );

    assign out_err = out_valid_reg & (|op_q_reg) & (chk != M'(1));
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_gf_inv_seq.sv
// tb_gf_inv_seq: randomized self-checking bench for gf_inv_seq.
// Two instances: M=3 (default polynomial) and M=4 (x^4+x+1). Expected
// inverses come from a brute-force reference: search b with a*b == 1,
// using integer carry-less multiply and long-division reduction.
module tb_gf_inv_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid3 = 1'b0;
    logic       in_ready3;
    logic [2:0] in_op3 = '0;
    logic       out_valid3;
    logic       out_ready3 = 1'b0;
    logic [2:0] out_res3;
    logic       out_err3;

    logic       in_valid4 = 1'b0;
    logic       in_ready4;
    logic [3:0] in_op4 = '0;
    logic       out_valid4;
    logic       out_ready4 = 1'b0;
    logic [3:0] out_res4;
    logic       out_err4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gf_inv_seq #(.M(3), .POLY(4'b1011)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_op     (in_op3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_res   (out_res3),
        .out_err   (out_err3)
    );

    gf_inv_seq #(.M(4), .POLY(5'b10011)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_op     (in_op4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_res   (out_res4),
        .out_err   (out_err4)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference field arithmetic.
    function automatic int ref_mul(input int a, input int b, input int m, input int poly);
        int p;
        p = 0;
        for (int i = 0; i < m; i++)
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 2 * m - 2; i >= m; i--)
            if (((p >> i) & 1) != 0) p = p ^ (poly << (i - m));
        return p;
    endfunction

    function automatic int ref_inv(input int a, input int m, input int poly);
        if (a == 0) return 0;
        for (int b = 1; b < (1 << m); b++)
            if (ref_mul(a, b, m, poly) == 1) return b;
        return -1;
    endfunction

    // One M=3 transaction; hold = cycles of out_ready=0 after out_valid.
    task automatic do_op3(input int op, input int hold);
        int cyc;
        int exp;
        exp = ref_inv(op, 3, 'b1011);
        check("m3_ready_before", int'(in_ready3), 1);
        in_valid3  = 1'b1;
        in_op3     = 3'(op);
        out_ready3 = (hold == 0);
        @(negedge clk);
        in_valid3 = 1'b0;
        cyc = 0;
        while (!out_valid3 && cyc < 20) begin
            check("m3_ready_busy", int'(in_ready3), 0);
            @(negedge clk);
            cyc++;
        end
        check("m3_latency", cyc, 2);
        check("m3_res", int'(out_res3), exp);
        check("m3_err", int'(out_err3), 0);
        check("m3_ready_done", int'(in_ready3), 0);
        for (int h = 0; h < hold; h++) begin
            in_valid3 = 1'b1;               // must be ignored while busy
            in_op3    = 3'(~op);
            @(negedge clk);
            check("m3_hold_valid", int'(out_valid3), 1);
            check("m3_hold_res", int'(out_res3), exp);
            check("m3_hold_ready", int'(in_ready3), 0);
        end
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
        @(negedge clk);
        check("m3_consumed_valid", int'(out_valid3), 0);
        check("m3_consumed_ready", int'(in_ready3), 1);
        $display("m3 op=%0d hold=%0d res=%0d exp=%0d lat=%0d", op, hold, out_res3, exp, cyc);
    endtask

    task automatic do_op4(input int op);
        int cyc;
        int exp;
        exp = ref_inv(op, 4, 'b10011);
        check("m4_ready_before", int'(in_ready4), 1);
        in_valid4  = 1'b1;
        in_op4     = 4'(op);
        out_ready4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        cyc = 0;
        while (!out_valid4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("m4_latency", cyc, 3);
        check("m4_res", int'(out_res4), exp);
        check("m4_err", int'(out_err4), 0);
        @(negedge clk);
        check("m4_consumed_ready", int'(in_ready4), 1);
        $display("m4 op=%0d res=%0d exp=%0d lat=%0d", op, out_res4, exp, cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready3), 1);
        check("rst_out_valid", int'(out_valid3), 0);
        check("rst_out_res", int'(out_res3), 0);
        check("rst_out_err", int'(out_err3), 0);
        check("rst4_out_valid", int'(out_valid4), 0);
        check("rst4_in_ready", int'(in_ready4), 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed values, then exhaustive M=3 sweep.
        do_op3(2, 0);
        do_op3(7, 0);
        do_op3(3, 0);
        for (int op = 0; op < 8; op++) do_op3(op, 0);

        // Backpressure with stray in_valid while busy.
        do_op3(5, 5);

        // Reset in the middle of CALC.
        in_valid3 = 1'b1;
        in_op3    = 3'd5;
        @(negedge clk);
        in_valid3 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", int'(out_valid3), 0);
        check("midrst_in_ready", int'(in_ready3), 1);
        @(negedge clk);
        check("midrst_idle_valid", int'(out_valid3), 0);
        $display("m3 mid-CALC reset out_valid=%0d in_ready=%0d", out_valid3, in_ready3);
        do_op3(4, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++)
            do_op3(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

        // M=4 instance.
        do_op4(2);
        do_op4(9);
        for (int i = 0; i < 20; i++) do_op4(int'($urandom_range(0, 15)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
